// File: rtl/cache_bank_arbiter_pkg.sv
// cache_bank_arbiter_pkg: shared sizing constants and arbiter state encoding
// for the cache data-array bank arbiter.
//   CACHE_INDEX_AW : row index width (256 rows)
//   RAM_NUM        : byte-RAMs per bank
//   DATA_WIDTH     : word width
//   LINE_BEATS     : refill beats per line (one word per bank)
package cache_bank_arbiter_pkg;

  localparam int unsigned CACHE_INDEX_AW = 8;
  localparam int unsigned RAM_NUM        = 4;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned LINE_BEATS     = 4;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_REFILL = 1'b1
  } arb_state_e;

endpackage

// File: rtl/cache_bank_arbiter_if.sv
// cache_bank_arbiter_if: requester/bank-side signal bundle of the arbiter.
//   master modport : cache control FSM / refill buffer side (drives *_i)
//   slave modport  : arbiter side (drives grants, handshakes, bank controls)
// Signals: lookup read (rd_*), store-hit write (st_*), line refill (rf_*),
// and the shared bank index / byte write enables / write data (bank_*).
interface cache_bank_arbiter_if
  import cache_bank_arbiter_pkg::*;
#(
  parameter int unsigned IDX_W = CACHE_INDEX_AW,
  parameter int unsigned NBANK = LINE_BEATS,
  parameter int unsigned NBYTE = RAM_NUM,
  parameter int unsigned DW    = DATA_WIDTH
);

  logic                     rd_req_i;
  logic [IDX_W-1:0]         rd_idx_i;
  logic                     rd_gnt_o;

  logic                     st_valid_i;
  logic [IDX_W-1:0]         st_idx_i;
  logic [1:0]               st_bank_i;
  logic [NBYTE-1:0]         st_strb_i;
  logic [DW-1:0]            st_data_i;
  logic                     st_ready_o;

  logic                     rf_start_i;
  logic [IDX_W-1:0]         rf_idx_i;
  logic                     rf_valid_i;
  logic [DW-1:0]            rf_data_i;
  logic                     rf_ready_o;
  logic                     rf_done_o;

  logic [IDX_W-1:0]         bank_idx_o;
  logic [NBANK*NBYTE-1:0]   bank_we_o;
  logic [DW-1:0]            bank_wdata_o;

  modport master (
    output rd_req_i, rd_idx_i,
    output st_valid_i, st_idx_i, st_bank_i, st_strb_i, st_data_i,
    output rf_start_i, rf_idx_i, rf_valid_i, rf_data_i,
    input  rd_gnt_o, st_ready_o, rf_ready_o, rf_done_o,
    input  bank_idx_o, bank_we_o, bank_wdata_o
  );

  modport slave (
    input  rd_req_i, rd_idx_i,
    input  st_valid_i, st_idx_i, st_bank_i, st_strb_i, st_data_i,
    input  rf_start_i, rf_idx_i, rf_valid_i, rf_data_i,
    output rd_gnt_o, st_ready_o, rf_ready_o, rf_done_o,
    output bank_idx_o, bank_we_o, bank_wdata_o
  );

endinterface

// File: rtl/cache_bank_arbiter_bank_we_decode.sv
// bank_we_decode: expands (bank select, byte strobes, enable) into the
// flat per-bank byte write-enable vector; bank b owns bits
// [b*NBYTE +: NBYTE]. Only the selected bank sees the strobes.
//   sel  : bank select
//   strb : byte strobes for the selected bank
//   en   : write enable
//   we   : NBANK*NBYTE byte enables
module bank_we_decode #(
  parameter int unsigned NBANK = 4,
  parameter int unsigned NBYTE = 4
) (
  input  logic [$clog2(NBANK)-1:0] sel,
  input  logic [NBYTE-1:0]         strb,
  input  logic                     en,
  output logic [NBANK*NBYTE-1:0]   we
);

  localparam int unsigned SEL_W = $clog2(NBANK);

  always_comb begin
    we = '0;
    for (int unsigned b = 0; b < NBANK; b++) begin
      if (en && (sel == SEL_W'(b))) begin
        we[b*NBYTE +: NBYTE] = strb;
      end
    end
  end

endmodule

// File: rtl/cache_bank_arbiter.sv
// cache_bank_arbiter: shares the 4-bank x 4-byte-RAM cache data array among
// the pipeline lookup read, the store-hit word write and the 4-beat line
// refill. Owns the common bank index mux and the per-bank byte enables.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : cache_bank_arbiter_if.slave (rd_*, st_*, rf_*, bank_*)
//   perf_st_stall_o / perf_rf_stall_o : saturating stall counters, present
//                only when CACHE_BANK_ARB_PERF_EN is defined
// Priority: read > refill start > store in IDLE; read > refill beat in
// REFILL. Outputs are combinational; only state, beat counter and the
// latched refill index are registered. Read data comes from the RAMs the
// cycle after rd_gnt_o and is not registered here.
module cache_bank_arbiter
  import cache_bank_arbiter_pkg::*;
#(
  parameter int unsigned IDX_W = CACHE_INDEX_AW,
  parameter int unsigned NBANK = LINE_BEATS,
  parameter int unsigned NBYTE = RAM_NUM,
  parameter int unsigned DW    = DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_bank_arbiter_if.slave  bus
`ifdef CACHE_BANK_ARB_PERF_EN
  ,
  output logic [31:0]          perf_st_stall_o,
  output logic [31:0]          perf_rf_stall_o
`endif
);

  localparam int unsigned BSEL_W = $clog2(NBANK);
  localparam int unsigned WE_W   = NBANK * NBYTE;

  arb_state_e         state;
  logic [BSEL_W-1:0]  cnt;
  logic [IDX_W-1:0]   rf_idx_q;

  logic               st_fire;
  logic               beat_fire;
  logic               rf_launch;
  logic               last_beat;
  logic [WE_W-1:0]    we_st;
  logic [WE_W-1:0]    we_rf;

  always_comb begin
    st_fire   = 1'b0;
    beat_fire = 1'b0;
    rf_launch = 1'b0;
    if (rst_n) begin
      case (state)
        ARB_IDLE: begin
          rf_launch = bus.rf_start_i;
          st_fire   = bus.st_valid_i & ~bus.rd_req_i & ~bus.rf_start_i;
        end
        ARB_REFILL: begin
          beat_fire = bus.rf_valid_i & ~bus.rd_req_i;
        end
        default: ;
      endcase
    end
  end

  assign last_beat = (cnt == BSEL_W'(NBANK - 1));

  bank_we_decode #(.NBANK(NBANK), .NBYTE(NBYTE)) u_we_st (
    .sel  (bus.st_bank_i[BSEL_W-1:0]),
    .strb (bus.st_strb_i),
    .en   (st_fire),
    .we   (we_st)
  );

  bank_we_decode #(.NBANK(NBANK), .NBYTE(NBYTE)) u_we_rf (
    .sel  (cnt),
    .strb ('1),
    .en   (beat_fire),
    .we   (we_rf)
  );

  always_comb begin
    bus.rd_gnt_o   = rst_n & bus.rd_req_i;
    bus.st_ready_o = st_fire;
    bus.rf_ready_o = rst_n & (state == ARB_REFILL) & ~bus.rd_req_i;
    bus.rf_done_o  = beat_fire & last_beat;
    bus.bank_we_o  = we_st | we_rf;

    bus.bank_idx_o   = '0;
    bus.bank_wdata_o = '0;
    if (rst_n && bus.rd_req_i) begin
      bus.bank_idx_o = bus.rd_idx_i;
    end else if (st_fire) begin
      bus.bank_idx_o   = bus.st_idx_i;
      bus.bank_wdata_o = bus.st_data_i;
    end else if (beat_fire) begin
      bus.bank_idx_o   = rf_idx_q;
      bus.bank_wdata_o = bus.rf_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      cnt      <= '0;
      rf_idx_q <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (rf_launch) begin
            state    <= ARB_REFILL;
            cnt      <= '0;
            rf_idx_q <= bus.rf_idx_i;
          end
        end
        ARB_REFILL: begin
          if (beat_fire) begin
            cnt <= cnt + 1'b1;
            if (last_beat) begin
              state <= ARB_IDLE;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef CACHE_BANK_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_st_stall_o <= '0;
      perf_rf_stall_o <= '0;
    end else begin
      if (bus.st_valid_i && !st_fire && (perf_st_stall_o != '1)) begin
        perf_st_stall_o <= perf_st_stall_o + 32'd1;
      end
      if ((state == ARB_REFILL) && bus.rf_valid_i && bus.rd_req_i &&
          (perf_rf_stall_o != '1)) begin
        perf_rf_stall_o <= perf_rf_stall_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_bank_arbiter.sv
// tb_cache_bank_arbiter: directed plus randomized check of cache_bank_arbiter
// against a behavioural model of the arbitration rules. A bench-side copy of
// the data array is filled from the bank write outputs to check refilled lines.
module tb_cache_bank_arbiter;
  import cache_bank_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_bank_arbiter_if bus ();

`ifdef CACHE_BANK_ARB_PERF_EN
  logic [31:0] perf_st, perf_rf;
`endif

  cache_bank_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CACHE_BANK_ARB_PERF_EN
    ,
    .perf_st_stall_o (perf_st),
    .perf_rf_stall_o (perf_rf)
`endif
  );

  int checks = 0;
  int errors = 0;

  // model state
  bit          m_ref;
  int          m_beat;
  logic [7:0]  m_idx;

  // expected outputs
  logic        e_gnt, e_st, e_rfr, e_done;
  logic [7:0]  e_idx;
  logic [15:0] e_we;
  logic [31:0] e_wd;

  // values observed in the last tick
  logic        l_st, l_done, l_gnt;
  logic [7:0]  l_idx;
  logic [15:0] l_we;

  logic [31:0] ram [4][256];
  logic [31:0] d_line [4];
  logic [15:0] we_tbl [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.rd_req_i   = 1'b0; bus.rd_idx_i = '0;
    bus.st_valid_i = 1'b0; bus.st_idx_i = '0; bus.st_bank_i = '0;
    bus.st_strb_i  = '0;   bus.st_data_i = '0;
    bus.rf_start_i = 1'b0; bus.rf_idx_i = '0;
    bus.rf_valid_i = 1'b0; bus.rf_data_i = '0;
  endtask

  task automatic model_exp();
    e_gnt = 0; e_st = 0; e_rfr = 0; e_done = 0;
    e_idx = '0; e_we = '0; e_wd = '0;
    if (rst_n) begin
      e_gnt = bus.rd_req_i;
      if (bus.rd_req_i) e_idx = bus.rd_idx_i;
      if (!m_ref) begin
        if (!bus.rd_req_i && !bus.rf_start_i && bus.st_valid_i) begin
          e_st  = 1;
          e_idx = bus.st_idx_i;
          e_wd  = bus.st_data_i;
          e_we  = 16'(bus.st_strb_i) << (4 * int'(bus.st_bank_i));
        end
      end else begin
        e_rfr = !bus.rd_req_i;
        if (e_rfr && bus.rf_valid_i) begin
          e_idx  = m_idx;
          e_wd   = bus.rf_data_i;
          e_we   = 16'hF << (4 * m_beat);
          e_done = (m_beat == 3);
        end
      end
    end
  endtask

  task automatic model_update();
    if (!rst_n) begin
      m_ref = 0; m_beat = 0;
    end else if (!m_ref) begin
      if (bus.rf_start_i) begin
        m_ref = 1; m_beat = 0; m_idx = bus.rf_idx_i;
      end
    end else if (bus.rf_valid_i && !bus.rd_req_i) begin
      m_beat++;
      if (m_beat == 4) begin
        m_ref = 0; m_beat = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_exp();
    chk("rd_gnt",     32'(bus.rd_gnt_o),     32'(e_gnt));
    chk("st_ready",   32'(bus.st_ready_o),   32'(e_st));
    chk("rf_ready",   32'(bus.rf_ready_o),   32'(e_rfr));
    chk("rf_done",    32'(bus.rf_done_o),    32'(e_done));
    chk("bank_idx",   32'(bus.bank_idx_o),   32'(e_idx));
    chk("bank_we",    32'(bus.bank_we_o),    32'(e_we));
    chk("bank_wdata", bus.bank_wdata_o,      e_wd);
    l_st = bus.st_ready_o; l_done = bus.rf_done_o; l_gnt = bus.rd_gnt_o;
    l_idx = bus.bank_idx_o; l_we = bus.bank_we_o;
    for (int b = 0; b < 4; b++)
      for (int y = 0; y < 4; y++)
        if (bus.bank_we_o[4*b+y] === 1'b1)
          ram[b][bus.bank_idx_o][8*y +: 8] = bus.bank_wdata_o[8*y +: 8];
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    int cyc;
    d_line[0] = 32'hD000_0000; d_line[1] = 32'hD111_1111;
    d_line[2] = 32'hD222_2222; d_line[3] = 32'hD333_3333;
    we_tbl[0] = 16'h000F; we_tbl[1] = 16'h00F0;
    we_tbl[2] = 16'h0F00; we_tbl[3] = 16'hF000;
    m_ref = 0; m_beat = 0; m_idx = '0;
    idle_inputs();

    // reset state
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // store without read
    bus.st_valid_i = 1; bus.st_idx_i = 8'h12; bus.st_bank_i = 2;
    bus.st_strb_i = 4'b0011; bus.st_data_i = 32'hA5A5_1234;
    tick();
    chk("tp_store_ready", 32'(l_st), 32'd1);
    chk("tp_store_we", 32'(l_we), 32'h0300);
    chk("tp_store_idx", 32'(l_idx), 32'h12);

    // read and store in the same cycle, then store alone
    bus.rd_req_i = 1; bus.rd_idx_i = 8'h05; bus.st_idx_i = 8'h07;
    tick();
    chk("tp_rdst_idx", 32'(l_idx), 32'h05);
    chk("tp_rdst_we", 32'(l_we), 32'h0);
    bus.rd_req_i = 0;
    tick();
    chk("tp_st_after_rd_idx", 32'(l_idx), 32'h07);

    // zero strobe still handshakes
    bus.st_strb_i = '0;
    tick();
    chk("tp_zero_strb_ready", 32'(l_st), 32'd1);
    chk("tp_zero_strb_we", 32'(l_we), 32'h0);

    // refill start with same-cycle store: store blocked
    idle_inputs();
    bus.rf_start_i = 1; bus.rf_idx_i = 8'h40;
    bus.st_valid_i = 1; bus.st_idx_i = 8'h77; bus.st_strb_i = 4'hF;
    tick();
    chk("tp_start_blocks_st", 32'(l_st), 32'd0);
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      bus.rf_valid_i = 1; bus.rf_data_i = d_line[i];
      tick();
      chk("tp_refill_we", 32'(l_we), 32'(we_tbl[i]));
      chk("tp_refill_done", 32'(l_done), (i == 3) ? 32'd1 : 32'd0);
    end
    // back in IDLE: beats ignored
    tick();
    idle_inputs();
    bus.rd_req_i = 1; bus.rd_idx_i = 8'h40;
    tick();
    for (int b = 0; b < 4; b++) chk("tp_line_content", ram[b][8'h40], d_line[b]);

    // read at beat 2 stalls one beat; also a stray start mid-refill
    idle_inputs();
    bus.rf_start_i = 1; bus.rf_idx_i = 8'h50;
    tick();
    bus.rf_start_i = 0;
    cyc = 0;
    l_done = 0;
    while (!l_done && cyc < 20) begin
      bus.rd_req_i   = (cyc == 2);
      bus.rd_idx_i   = 8'h33;
      bus.rf_start_i = (cyc == 1);
      bus.rf_idx_i   = 8'h99;
      bus.rf_valid_i = 1;
      bus.rf_data_i  = $urandom;
      tick();
      cyc++;
    end
    chk("tp_stall_cycles", 32'(cyc), 32'd5);

    // reset in the middle of a refill
    idle_inputs();
    bus.rf_start_i = 1; bus.rf_idx_i = 8'h60;
    tick();
    bus.rf_start_i = 0;
    bus.rf_valid_i = 1; bus.rf_data_i = d_line[0];
    tick();
    bus.rf_data_i = d_line[1];
    tick();
    rst_n = 1'b0;
    #1;
    chk("tp_rst_rf_ready", 32'(bus.rf_ready_o), 32'd0);
    chk("tp_rst_we", 32'(bus.bank_we_o), 32'd0);
    chk("tp_rst_idx", 32'(bus.bank_idx_o), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.rf_valid_i = 0;
    // three stalled store cycles
    bus.rd_req_i = 1; bus.rd_idx_i = 8'h02;
    bus.st_valid_i = 1; bus.st_idx_i = 8'h41; bus.st_strb_i = 4'hF;
    bus.st_data_i = 32'h1234_5678;
    tick(); tick(); tick();
`ifdef CACHE_BANK_ARB_PERF_EN
    chk("tp_perf_st_stall", perf_st, 32'd3);
`endif
    bus.rd_req_i = 0;
    tick();
    chk("tp_post_rst_store", 32'(l_st), 32'd1);
    chk("tp_post_rst_idx", 32'(l_idx), 32'h41);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      bus.rd_req_i   = ($urandom_range(0, 2) == 0);
      bus.rd_idx_i   = 8'($urandom);
      bus.st_valid_i = $urandom_range(0, 1) == 1;
      bus.st_idx_i   = 8'($urandom);
      bus.st_bank_i  = 2'($urandom);
      bus.st_strb_i  = 4'($urandom);
      bus.st_data_i  = $urandom;
      bus.rf_start_i = ($urandom_range(0, 7) == 0);
      bus.rf_idx_i   = 8'($urandom);
      bus.rf_valid_i = $urandom_range(0, 1) == 1;
      bus.rf_data_i  = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_bank_arbiter.md
Name: cache_bank_arbiter

Overview:
- Sequences and shares the four-bank cache data array (4 banks x 4 byte-RAMs, 256 rows) among three requesters.
- Requesters: pipeline read lookup, store-hit word write, and 4-beat line refill.
- The bank index is common to the read and write ports, so the block owns the index mux and the per-bank byte write enables.
- Sits between the cache control FSM / refill buffer and the data-array banks.

Parameters:
- IDX_W, `CACHE_INDEX_AW (8), row index width
- NBANK, 4, banks per line (words per line)
- NBYTE, `RAM_NUM (4), byte-RAMs per bank
- DW, `DATA_WIDTH (32), word width

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- rd_req_i  in  1  lookup read request
- rd_idx_i  in  IDX_W  lookup index
- rd_gnt_o  out  1  lookup granted this cycle
- st_valid_i  in  1  store-hit write request
- st_idx_i  in  IDX_W  store index
- st_bank_i  in  2  store word select
- st_strb_i  in  NBYTE  store byte strobes
- st_data_i  in  DW  store data
- st_ready_o  out  1  store accepted
- rf_start_i  in  1  refill start pulse
- rf_idx_i  in  IDX_W  refill line index
- rf_valid_i  in  1  refill beat valid
- rf_data_i  in  DW  refill beat data
- rf_ready_o  out  1  refill beat accepted
- rf_done_o  out  1  pulse, last beat written
- bank_idx_o  out  IDX_W  index to all banks
- bank_we_o  out  NBANK*NBYTE  byte enables; bank b uses bits [4b+3:4b]
- bank_wdata_o  out  DW  write data broadcast to all banks

Behaviour:
- Reset: state IDLE, beat counter 0; all outputs 0.
- States: IDLE, REFILL. Outputs combinational from state and inputs; only state, beat counter and latched refill index are registered.
- IDLE priority: rd_req_i > st_valid_i. rd_gnt_o=rd_req_i; bank_idx_o=rd_idx_i when rd_req_i.
- Store in IDLE without rd_req_i:
  - st_ready_o=1; bank_idx_o=st_idx_i; bank_wdata_o=st_data_i.
  - bank_we_o[4*st_bank_i +: 4]=st_strb_i; other bits 0.
  - st_strb_i=0 still handshakes, no RAM write.
- rf_start_i in IDLE:
  - Latch rf_idx_i, counter cleared to 0, next state REFILL.
  - rf_start_i has priority over a same-cycle store: st_ready_o=0 that cycle. A same-cycle read is still granted.
- REFILL:
  - rf_ready_o=1 only when rd_req_i=0. Reads keep priority and stall beats, so no read sees a half-written row.
  - Reads are granted in REFILL with bank_idx_o=rd_idx_i.
  - Beat accepted (rf_valid_i & rf_ready_o): bank_idx_o=latched index; bank_we_o[4*cnt +: 4]=4'hF; bank_wdata_o=rf_data_i; counter increments.
  - Beat at cnt==3: rf_done_o=1 the same cycle, counter wraps to 0, next state IDLE.
- st_ready_o=0 throughout REFILL.
- rf_start_i during REFILL is ignored (protocol error, no effect).
- rf_valid_i in IDLE is ignored; rf_ready_o=0.
- Read path latency: bank RAM is synchronous, data valid the cycle after rd_gnt_o. This block does not register read data.
- Reset mid-refill: immediate return to IDLE, counter 0, no further writes; the partial line stays in the RAM and the tag must not be validated.

Optional Feature:
- Macro CACHE_BANK_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_st_stall_o[31:0] and perf_rf_stall_o[31:0], reset 0.
  - perf_st_stall_o counts cycles with st_valid_i & ~st_ready_o.
  - perf_rf_stall_o counts cycles in REFILL with rf_valid_i & rd_req_i.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared defines file: state encodings (ARB_IDLE=1'b0, ARB_REFILL=1'b1) and LINE_BEATS=4, next to the existing `CACHE_INDEX_AW / `RAM_NUM / `DATA_WIDTH.
- One natural sub-module, bank_we_decode: (bank select 2b, strobe 4b, enable) -> 16-bit one-hot-bank byte-enable vector. Reused for the store and refill paths.

Test Plan:
- Store, no read: st_idx=8'h12, bank=2, strb=4'b0011, data=32'hA5A5_1234 -> st_ready=1, bank_idx=8'h12, bank_we=16'h0300, wdata=32'hA5A5_1234.
- Read and store same cycle: rd_idx=8'h05, st_idx=8'h07 -> rd_gnt=1, bank_idx=8'h05, st_ready=0, bank_we=0. Next cycle with rd_req=0: store writes at 8'h07.
- Refill at 8'h40, beats D0..D3 back-to-back, no reads -> bank_we 16'h000F, 16'h00F0, 16'h0F00, 16'hF000 on 4 consecutive cycles. rf_done=1 with D3. Back to IDLE; later read of 8'h40 returns D0..D3 per bank.
- Read in mid-refill at beat 2 -> rf_ready=0 that cycle, bank_idx=rd_idx, no write. Beat 2 is written the following cycle; total 5 cycles.
- rst_n low after beat 1 -> outputs 0 immediately, state IDLE. After release, a store to 8'h41 is accepted in 1 cycle.
- With CACHE_BANK_ARB_PERF_EN: 3 cycles of store blocked by reads -> perf_st_stall_o=3.
